// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ID/EX ALU operand stage: forward-select encoding
// and immediate extension.
package alu_operand_pkg;

    localparam int FWD_RF    = 0;    // select value meaning "register file"
    localparam int IMM_MAX_W = 128;  // widest datapath ext_imm16 can produce

    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Result is IMM_MAX_W wide; callers truncate to their datapath width.
    function automatic logic [IMM_MAX_W-1:0] ext_imm16(input logic [15:0] imm,
                                                       input logic        sext,
                                                       input int          width);
        logic [IMM_MAX_W-1:0] r;
        r       = '0;
        r[15:0] = imm;
        for (int i = 16; i < IMM_MAX_W; i++)
            if (i < width) r[i] = sext & imm[15];
        return r;
    endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// One operand's forwarding mux: register file or one of NFWD forwarded results.
// Out-of-range selects fall back to the register file and raise illegal.
module fwd_mux
    import alu_operand_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NFWD  = 3,
    parameter int SELW  = sel_width(NFWD)
) (
    input  logic [SELW-1:0]       sel,
    input  logic [WIDTH-1:0]      rf,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    output logic [WIDTH-1:0]      out,
    output logic                  illegal
);

    always_comb begin
        out     = rf;
        illegal = int'(sel) > NFWD;
        for (int k = FWD_RF + 1; k <= NFWD; k++)
            if (sel == SELW'(k)) out = fwd_data[k*WIDTH-1 -: WIDTH];
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX boundary: resolves ALU operands A/B and store data in ID, registers
// them into EX with stall (hold) and flush (bubble) control.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NFWD  = 3,
    parameter int SELW  = sel_width(NFWD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    input  logic [WIDTH-1:0]      d_qa,
    input  logic [WIDTH-1:0]      d_qb,
    input  logic [SELW-1:0]       d_fwda,
    input  logic [SELW-1:0]       d_fwdb,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    input  logic [15:0]           d_imm16,
    input  logic                  d_sext,
    input  logic                  d_aluimm,
    input  logic                  d_shift,
    input  logic [4:0]            d_sa,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  e_valid,
    output logic [WIDTH-1:0]      e_a,
    output logic [WIDTH-1:0]      e_b,
    output logic [WIDTH-1:0]      e_qb,
    output logic                  sel_err
);

    logic [WIDTH-1:0] fa, fb, imm, op_a, op_b;
    logic             ill_a, ill_b, load;

    fwd_mux #(.WIDTH(WIDTH), .NFWD(NFWD), .SELW(SELW)) u_fwd_a (
        .sel(d_fwda), .rf(d_qa), .fwd_data(fwd_data), .out(fa), .illegal(ill_a)
    );

    fwd_mux #(.WIDTH(WIDTH), .NFWD(NFWD), .SELW(SELW)) u_fwd_b (
        .sel(d_fwdb), .rf(d_qb), .fwd_data(fwd_data), .out(fb), .illegal(ill_b)
    );

    assign imm  = WIDTH'(ext_imm16(d_imm16, d_sext, WIDTH));
    assign op_a = d_shift ? {{(WIDTH-5){1'b0}}, d_sa} : fa;
    assign op_b = d_aluimm ? imm : fb;
    assign load = !flush && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_a     <= '0;
            e_b     <= '0;
            e_qb    <= '0;
        end else if (flush) begin
            e_valid <= 1'b0;
            e_a     <= '0;
            e_b     <= '0;
            e_qb    <= '0;
        end else if (!stall) begin
            // data loads even for invalid slots so EX never sees stale values
            e_valid <= d_valid;
            e_a     <= op_a;
            e_b     <= op_b;
            e_qb    <= fb;
        end
    end

    // sticky until reset; only a real (valid, loaded) instruction can flag
    always_ff @(posedge clk) begin
        if (rst)
            sel_err <= 1'b0;
        else if (load && d_valid && (ill_a || ill_b))
            sel_err <= 1'b1;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: vector table on a 32b/3-source
// instance plus hand sequences for illegal selects and width variants.
module tb_alu_operand_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // shared control
    logic        rst, d_valid, d_sext, d_aluimm, d_shift, stall, flush;
    logic [15:0] d_imm16;
    logic [4:0]  d_sa;
    logic [31:0] d_qa, d_qb;

    // WIDTH=32 NFWD=3
    logic [1:0]  fwda3, fwdb3;
    logic [95:0] fwd3;
    logic        ev3, err3;
    logic [31:0] a3, b3, qb3;

    // WIDTH=32 NFWD=2
    logic [1:0]  fwda2, fwdb2;
    logic [63:0] fwd2;
    logic        ev2, err2;
    logic [31:0] a2, b2, qb2;

    // WIDTH=16 NFWD=1
    logic [0:0]  fwda16, fwdb16;
    logic [15:0] qa16, qbi16, fwd16;
    logic        ev16, err16;
    logic [15:0] a16, b16, qb16;

    // WIDTH=64 NFWD=1
    logic [0:0]  fwda64, fwdb64;
    logic [63:0] qa64, qbi64, fwd64;
    logic        ev64, err64;
    logic [63:0] a64, b64, qb64;

    alu_operand_stage #(.WIDTH(32), .NFWD(3)) u3 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_qa(d_qa), .d_qb(d_qb),
        .d_fwda(fwda3), .d_fwdb(fwdb3), .fwd_data(fwd3), .d_imm16(d_imm16),
        .d_sext(d_sext), .d_aluimm(d_aluimm), .d_shift(d_shift), .d_sa(d_sa),
        .stall(stall), .flush(flush), .e_valid(ev3), .e_a(a3), .e_b(b3),
        .e_qb(qb3), .sel_err(err3)
    );

    alu_operand_stage #(.WIDTH(32), .NFWD(2)) u2 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_qa(d_qa), .d_qb(d_qb),
        .d_fwda(fwda2), .d_fwdb(fwdb2), .fwd_data(fwd2), .d_imm16(d_imm16),
        .d_sext(d_sext), .d_aluimm(d_aluimm), .d_shift(d_shift), .d_sa(d_sa),
        .stall(stall), .flush(flush), .e_valid(ev2), .e_a(a2), .e_b(b2),
        .e_qb(qb2), .sel_err(err2)
    );

    alu_operand_stage #(.WIDTH(16), .NFWD(1)) u16 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_qa(qa16), .d_qb(qbi16),
        .d_fwda(fwda16), .d_fwdb(fwdb16), .fwd_data(fwd16), .d_imm16(d_imm16),
        .d_sext(d_sext), .d_aluimm(d_aluimm), .d_shift(d_shift), .d_sa(d_sa),
        .stall(stall), .flush(flush), .e_valid(ev16), .e_a(a16), .e_b(b16),
        .e_qb(qb16), .sel_err(err16)
    );

    alu_operand_stage #(.WIDTH(64), .NFWD(1)) u64 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_qa(qa64), .d_qb(qbi64),
        .d_fwda(fwda64), .d_fwdb(fwdb64), .fwd_data(fwd64), .d_imm16(d_imm16),
        .d_sext(d_sext), .d_aluimm(d_aluimm), .d_shift(d_shift), .d_sa(d_sa),
        .stall(stall), .flush(flush), .e_valid(ev64), .e_a(a64), .e_b(b64),
        .e_qb(qb64), .sel_err(err64)
    );

    typedef struct {
        logic        valid;
        logic [31:0] qa, qb;
        logic [1:0]  fwda, fwdb;
        logic [15:0] imm;
        logic        sext, aluimm, shift;
        logic [4:0]  sa;
        logic        stall, flush;
        logic        ev;
        logic [31:0] ea, eb, eqb;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{1'b1, 32'hAA, 32'hBB, 2'd0, 2'd1, 16'h8001, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0,
                   1'b1, 32'hAA, 32'hFFFF8001, 32'h11};
        tv[1]  = '{1'b1, 32'hAA, 32'hBB, 2'd0, 2'd2, 16'h8001, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0,
                   1'b1, 32'hAA, 32'h00008001, 32'h22};
        tv[2]  = '{1'b1, 32'hAA, 32'hBB, 2'd2, 2'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0,
                   1'b1, 32'h22, 32'h33, 32'h33};
        tv[3]  = '{1'b1, 32'hAA, 32'hBB, 2'd2, 2'd3, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0,
                   1'b1, 32'h1F, 32'h33, 32'h33};
        tv[4]  = '{1'b0, 32'hAA, 32'hBB, 2'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0,
                   1'b0, 32'hAA, 32'hBB, 32'hBB};
        tv[5]  = '{1'b1, 32'h5,  32'h7,  2'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0,
                   1'b1, 32'h5, 32'h7, 32'h7};
        tv[6]  = '{1'b1, 32'h9,  32'h8,  2'd1, 2'd2, 16'h1234, 1'b1, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0,
                   1'b1, 32'h5, 32'h7, 32'h7};
        tv[7]  = '{1'b0, 32'h99, 32'h98, 2'd3, 2'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0,
                   1'b1, 32'h5, 32'h7, 32'h7};
        tv[8]  = '{1'b1, 32'h0,  32'h0,  2'd2, 2'd1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0,
                   1'b1, 32'h5, 32'h7, 32'h7};
        tv[9]  = '{1'b1, 32'h9,  32'h8,  2'd1, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1,
                   1'b0, 32'h0, 32'h0, 32'h0};
        tv[10] = '{1'b1, 32'h44, 32'h55, 2'd1, 2'd3, 16'h7FFF, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0,
                   1'b1, 32'h11, 32'h00007FFF, 32'h33};

        fwd3 = {32'h33, 32'h22, 32'h11};
        fwd2 = {32'h2222, 32'h1111};
        fwda2 = 2'd0; fwdb2 = 2'd0;
        fwda16 = 1'b0; fwdb16 = 1'b0; qa16 = 16'h0; qbi16 = 16'h0; fwd16 = 16'h0;
        fwda64 = 1'b0; fwdb64 = 1'b0; qa64 = 64'h0; qbi64 = 64'h0; fwd64 = 64'h0;

        // reset with arbitrary inputs
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        d_valid = 1'b1; d_qa = $urandom; d_qb = $urandom; fwda3 = 2'd1; fwdb3 = 2'd2;
        d_imm16 = 16'($urandom); d_sext = 1'b1; d_aluimm = 1'b1; d_shift = 1'b0; d_sa = 5'd7;
        step();
        chk("rst_valid", 64'(ev3), 64'h0);
        chk("rst_a",     64'(a3),  64'h0);
        chk("rst_b",     64'(b3),  64'h0);
        chk("rst_qb",    64'(qb3), 64'h0);
        chk("rst_err",   64'(err3), 64'h0);
        stall = 1'b1;
        d_qa = 32'hDEAD; d_valid = 1'b1;
        step();
        chk("rst_stall_valid", 64'(ev3), 64'h0);
        chk("rst_stall_a",     64'(a3),  64'h0);
        chk("rst_stall_a64",   a64,      64'h0);

        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            d_valid = tv[i].valid; d_qa = tv[i].qa; d_qb = tv[i].qb;
            fwda3 = tv[i].fwda; fwdb3 = tv[i].fwdb; d_imm16 = tv[i].imm;
            d_sext = tv[i].sext; d_aluimm = tv[i].aluimm; d_shift = tv[i].shift;
            d_sa = tv[i].sa; stall = tv[i].stall; flush = tv[i].flush;
            step();
            chk($sformatf("v%0d_valid", i), 64'(ev3), 64'(tv[i].ev));
            chk($sformatf("v%0d_a", i),     64'(a3),  64'(tv[i].ea));
            chk($sformatf("v%0d_b", i),     64'(b3),  64'(tv[i].eb));
            chk($sformatf("v%0d_qb", i),    64'(qb3), 64'(tv[i].eqb));
        end
        chk("n3_no_err", 64'(err3), 64'h0);

        // illegal select on the NFWD=2 instance
        stall = 1'b0; flush = 1'b0; d_aluimm = 1'b0; d_shift = 1'b0;
        d_qa = 32'hA0; d_qb = 32'hB0; fwda2 = 2'd1; fwdb2 = 2'd3; d_valid = 1'b0;
        step();
        chk("ill_inv_err", 64'(err2), 64'h0);
        chk("ill_inv_b",   64'(b2),   64'hB0);
        d_valid = 1'b1;
        step();
        chk("ill_b",    64'(b2),  64'hB0);
        chk("ill_qb",   64'(qb2), 64'hB0);
        chk("ill_a",    64'(a2),  64'h1111);
        chk("ill_err",  64'(err2), 64'h1);
        fwdb2 = 2'd0; flush = 1'b1;
        step();
        chk("ill_flush_err",   64'(err2), 64'h1);
        chk("ill_flush_valid", 64'(ev2),  64'h0);
        flush = 1'b0;
        step();
        chk("ill_hold_err", 64'(err2), 64'h1);
        rst = 1'b1;
        step();
        chk("ill_rst_err", 64'(err2), 64'h0);
        rst = 1'b0; fwda2 = 2'd3; d_shift = 1'b1; d_sa = 5'd9;
        step();
        chk("ill_shift_a",   64'(a2),  64'h9);
        chk("ill_shift_err", 64'(err2), 64'h1);

        // width sweep, NFWD=1
        rst = 1'b1; step(); rst = 1'b0;
        d_valid = 1'b1; d_shift = 1'b0; d_aluimm = 1'b1; d_sext = 1'b1; d_imm16 = 16'h8001;
        qa16 = 16'h1A1A; qbi16 = 16'h2B2B; fwd16 = 16'hC0DE; fwda16 = 1'b1; fwdb16 = 1'b1;
        qa64 = 64'h1111_0000_0000_1111; qbi64 = 64'h2222_0000_0000_2222;
        fwd64 = 64'hFEDC_BA98_7654_3210; fwda64 = 1'b1; fwdb64 = 1'b1;
        step();
        chk("w16_b_sext",  64'(b16),  64'h8001);
        chk("w16_a_fwd",   64'(a16),  64'hC0DE);
        chk("w16_qb_fwd",  64'(qb16), 64'hC0DE);
        chk("w64_b_sext",  b64,  64'hFFFF_FFFF_FFFF_8001);
        chk("w64_a_fwd",   a64,  64'hFEDC_BA98_7654_3210);
        chk("w64_qb_fwd",  qb64, 64'hFEDC_BA98_7654_3210);
        d_sext = 1'b0;
        step();
        chk("w64_b_zext", b64, 64'h8001);
        d_aluimm = 1'b0; fwda64 = 1'b0; fwdb64 = 1'b0; fwda16 = 1'b0; fwdb16 = 1'b0;
        d_shift = 1'b1; d_sa = 5'd17;
        step();
        chk("w64_b_rf",    b64, 64'h2222_0000_0000_2222);
        chk("w64_a_shift", a64, 64'd17);
        chk("w16_b_rf",    64'(b16), 64'h2B2B);
        chk("w_no_err",    64'({err16, err64}), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
